// File: rtl/vector_recorder.sv
// Test-vector capture buffer: records qualified samples after a trigger, then plays them back one word per rd_en.
// Optional pre-trigger ring capture is enabled by defining VREC_PRETRIG_EN.
module vector_recorder #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     stop,
  input  logic                     sample_en,
  input  logic [WIDTH-1:0]         vec_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            we_c;
  logic            rd_c;
  logic            fill_c;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;
  logic [WIDTH-1:0] mem [DEPTH];
`ifdef VREC_PRETRIG_EN
  logic [CW-1:0]   budget;
`endif

  // Oldest stored word always sits count entries behind the write pointer.
  assign rd_addr = wr_ptr - AW'(count);
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    we_c    = 1'b0;
    rd_c    = 1'b0;
    fill_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
`ifdef VREC_PRETRIG_EN
        we_c = sample_en;
`else
        we_c = sample_en && trig;
`endif
        if (trig) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        we_c = sample_en;
`ifdef VREC_PRETRIG_EN
        fill_c = sample_en && (budget == CW'(1));
`else
        fill_c = sample_en && (count == CW'(DEPTH - 1));
`endif
        if (stop || fill_c) state_d = S_DONE;
      end
      S_DONE: begin
        rd_c = rd_en && (count != CW'(0));
        if (count == CW'(0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset && we_c) mem[wr_ptr] <= vec_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
`ifdef VREC_PRETRIG_EN
      budget   <= '0;
`endif
    end else begin
      rd_valid <= rd_c;
      if (rd_c) begin
        rd_data <= mem[rd_addr];
        count   <= count - CW'(1);
      end
      if (state_q == S_IDLE && arm) begin
        overrun <= 1'b0;
        wr_ptr  <= '0;
        count   <= '0;
      end
      if (state_q == S_DONE && sample_en) overrun <= 1'b1;
      // Count saturates so a full ring keeps overwriting its oldest entry.
      if (we_c) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) count <= count + CW'(1);
      end
`ifdef VREC_PRETRIG_EN
      if (state_q == S_ARMED && trig)
        budget <= CW'(DEPTH / 2) - CW'(sample_en);
      else if (state_q == S_CAPTURE && sample_en)
        budget <= budget - CW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_vector_recorder.sv
// Self-checking bench for vector_recorder: directed scenarios plus randomized sessions
// compared against a queue-based behavioural model.
module tb_vector_recorder;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             arm;
  logic             trig;
  logic             stop;
  logic             sample_en;
  logic [WIDTH-1:0] vec_in;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [4:0]       count;
  logic [1:0]       state;
  logic             overrun;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: stored words live in a FIFO queue.
  int               m_state = 0;
  logic [WIDTH-1:0] m_q[$];
  logic             m_ov  = 1'b0;
  logic             m_rdv = 1'b0;
  logic [WIDTH-1:0] m_rdd = '0;
  int               m_budget = 0;

  vector_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .stop(stop),
    .sample_en(sample_en), .vec_in(vec_in), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .state(state), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void push_word(input logic [WIDTH-1:0] w);
    m_q.push_back(w);
    if (m_q.size() > DEPTH) void'(m_q.pop_front());
  endfunction

  function automatic void model_step();
    if (!reset) begin
      m_state = 0; m_q.delete(); m_rdv = 1'b0; m_rdd = '0; m_ov = 1'b0;
      return;
    end
    m_rdv = 1'b0;
    case (m_state)
      0: if (arm) begin m_state = 1; m_ov = 1'b0; m_q.delete(); end
      1: begin
`ifdef VREC_PRETRIG_EN
        if (sample_en) push_word(vec_in);
        if (trig) begin m_budget = DEPTH / 2 - (sample_en ? 1 : 0); m_state = 2; end
`else
        if (trig) begin
          if (sample_en) push_word(vec_in);
          m_state = 2;
        end
`endif
      end
      2: begin
        if (sample_en) begin push_word(vec_in); m_budget--; end
`ifdef VREC_PRETRIG_EN
        if (stop || m_budget == 0) m_state = 3;
`else
        if (stop || m_q.size() == DEPTH) m_state = 3;
`endif
      end
      default: begin
        if (sample_en) m_ov = 1'b1;
        if (m_q.size() == 0) m_state = 0;
        else if (rd_en) begin m_rdd = m_q.pop_front(); m_rdv = 1'b1; end
      end
    endcase
  endfunction

  function automatic logic [20:0] dut_snap();
    return {state, count, rd_valid, overrun, rd_data};
  endfunction

  function automatic logic [20:0] model_snap();
    return {2'(m_state), 5'(m_q.size()), m_rdv, m_ov, m_rdd};
  endfunction

  task automatic drive(input logic a, input logic t, input logic s, input logic se,
                       input logic [WIDTH-1:0] v, input logic r);
    arm = a; trig = t; stop = s; sample_en = se; vec_in = v; rd_en = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, '0, 0);
    tick(); tick();
    n_checks++;
    if (dut_snap() !== 21'h0) $display("FAIL reset_state got %h want %h", dut_snap(), 21'h0);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 1, 0, 1, 12'h000, 0); tick();
    for (int i = 1; i < 16; i++) begin drive(0, 0, 0, 1, 12'(i), 0); tick(); end
    drive(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({state, count} !== {2'd3, 5'd16}) $display("FAIL basic_full got %h want %h", {state, count}, {2'd3, 5'd16});
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; tick();
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, 12'(i)})
        $display("FAIL basic_read%0d got %h want %h", i, {rd_valid, rd_data}, {1'b1, 12'(i)});
      else n_pass++;
    end
    rd_en = 1'b0; tick();
    n_checks++;
    if (dut_snap() !== model_snap() || state !== 2'd0) $display("FAIL basic_idle got %h want %h", dut_snap(), model_snap());
    else n_pass++;
  endtask

`ifdef VREC_PRETRIG_EN
  task automatic test_pretrig();
    drive(1, 0, 0, 0, '0, 0); tick();
    for (int i = 0; i < 20; i++) begin drive(0, 0, 0, 1, 12'(i), 0); tick(); end
    n_checks++;
    if ({state, count} !== {2'd1, 5'd16}) $display("FAIL pretrig_ring got %h want %h", {state, count}, {2'd1, 5'd16});
    else n_pass++;
    drive(0, 1, 0, 1, 12'd20, 0); tick();
    for (int i = 21; i < 28; i++) begin drive(0, 0, 0, 1, 12'(i), 0); tick(); end
    drive(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({state, count} !== {2'd3, 5'd16}) $display("FAIL pretrig_done got %h want %h", {state, count}, {2'd3, 5'd16});
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; tick();
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, 12'(12 + i)})
        $display("FAIL pretrig_read%0d got %h want %h", i, {rd_valid, rd_data}, {1'b1, 12'(12 + i)});
      else n_pass++;
    end
    rd_en = 1'b0; tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL pretrig_idle got %0d want 0", state);
    else n_pass++;
  endtask
`endif

  task automatic test_early_stop();
    logic [WIDTH-1:0] w;
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 1, 0, 1, 12'hA01, 0); tick();
    drive(0, 0, 0, 1, 12'hA02, 0); tick();
    drive(0, 0, 0, 1, 12'hA03, 0); tick();
    drive(0, 0, 1, 1, 12'hA04, 0); tick();
    drive(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({state, count} !== {2'd3, 5'd4}) $display("FAIL stop_count got %h want %h", {state, count}, {2'd3, 5'd4});
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1; tick();
      w = (k < 4) ? 12'hA01 + 12'(k) : 12'hA04;
      n_checks++;
      if ({rd_valid, rd_data} !== {(k < 4), w})
        $display("FAIL stop_read%0d got %h want %h", k, {rd_valid, rd_data}, {(k < 4), w});
      else n_pass++;
    end
    rd_en = 1'b0;
    n_checks++;
    if (state !== 2'd0) $display("FAIL stop_idle got %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_boundaries();
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 1, 0, 0, '0, 0); tick();
    drive(0, 0, 1, 0, '0, 0); tick();
    drive(0, 0, 0, 0, '0, 0);
    n_checks++;
    if ({state, count} !== {2'd3, 5'd0}) $display("FAIL empty_done got %h want %h", {state, count}, {2'd3, 5'd0});
    else n_pass++;
    tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL empty_idle got %0d want 0", state);
    else n_pass++;
    rd_en = 1'b1; tick();
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL rd_in_idle got %b want 0", rd_valid);
    else n_pass++;
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 0, 0, 0, '0, 1); tick();
    n_checks++;
    if ({state, rd_valid} !== {2'd1, 1'b0}) $display("FAIL rd_in_armed got %h want %h", {state, rd_valid}, {2'd1, 1'b0});
    else n_pass++;
    drive(0, 1, 0, 1, 12'h5A5, 0); tick();
    drive(0, 0, 1, 0, '0, 0); tick();
    drive(0, 0, 0, 1, 12'hFFF, 0); tick();
    n_checks++;
    if ({overrun, count} !== {1'b1, 5'd1}) $display("FAIL overrun_set got %h want %h", {overrun, count}, {1'b1, 5'd1});
    else n_pass++;
    drive(0, 0, 0, 0, '0, 1); tick();
    n_checks++;
    if ({rd_valid, rd_data} !== {1'b1, 12'h5A5}) $display("FAIL overrun_read got %h want %h", {rd_valid, rd_data}, {1'b1, 12'h5A5});
    else n_pass++;
    drive(0, 0, 0, 0, '0, 0); tick();
    n_checks++;
    if ({state, overrun} !== {2'd0, 1'b1}) $display("FAIL overrun_sticky got %h want %h", {state, overrun}, {2'd0, 1'b1});
    else n_pass++;
    drive(1, 0, 0, 0, '0, 0); tick();
    n_checks++;
    if ({state, overrun} !== {2'd1, 1'b0}) $display("FAIL overrun_clear got %h want %h", {state, overrun}, {2'd1, 1'b0});
    else n_pass++;
    drive(0, 1, 0, 0, '0, 0); tick();
    drive(0, 0, 1, 0, '0, 0); tick();
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 1, 0, 1, 12'h0C0, 0); tick();
    for (int i = 1; i < 5; i++) begin drive(0, 0, 0, 1, 12'h0C0 + 12'(i), 0); tick(); end
    drive(0, 0, 0, 0, '0, 0);
    reset = 1'b0; tick(); reset = 1'b1;
    n_checks++;
    if ({state, count, rd_valid} !== 8'h0) $display("FAIL midreset got %h want %h", {state, count, rd_valid}, 8'h0);
    else n_pass++;
    drive(1, 0, 0, 0, '0, 0); tick();
    drive(0, 1, 0, 1, 12'h111, 0); tick();
    drive(0, 0, 0, 1, 12'h222, 0); tick();
    drive(0, 0, 1, 1, 12'h333, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, '0, 1); tick();
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, 12'h111 * 12'(i + 1)})
        $display("FAIL midreset_read%0d got %h want %h", i, {rd_valid, rd_data}, {1'b1, 12'h111 * 12'(i + 1)});
      else n_pass++;
    end
    drive(0, 0, 0, 0, '0, 0); tick();
  endtask

  task automatic test_random();
    int cyc;
    for (int sess = 0; sess < 8; sess++) begin
      drive(1, 0, 0, 0, '0, 0); tick();
      for (int i = 0; i < int'($urandom_range(0, 24)); i++) begin
        drive(0, 0, 0, $urandom_range(0, 1) == 1, 12'($urandom), $urandom_range(0, 1) == 1); tick();
        n_checks++;
        if (dut_snap() !== model_snap()) $display("FAIL rnd_armed got %h want %h", dut_snap(), model_snap());
        else n_pass++;
      end
      drive(0, 1, 0, $urandom_range(0, 1) == 1, 12'($urandom), 0); tick();
      cyc = 0;
      while (m_state == 2 && cyc < 40) begin
        drive(0, 0, ($urandom_range(0, 11) == 0) || cyc == 39, $urandom_range(0, 3) != 0, 12'($urandom),
              $urandom_range(0, 1) == 1);
        tick(); cyc++;
        n_checks++;
        if (dut_snap() !== model_snap()) $display("FAIL rnd_capture got %h want %h", dut_snap(), model_snap());
        else n_pass++;
      end
      cyc = 0;
      while (m_state != 0 && cyc < 100) begin
        drive(0, 0, 0, $urandom_range(0, 9) == 0, 12'($urandom), $urandom_range(0, 2) != 0);
        tick(); cyc++;
        n_checks++;
        if (dut_snap() !== model_snap()) $display("FAIL rnd_readout got %h want %h", dut_snap(), model_snap());
        else n_pass++;
      end
      n_checks++;
      if (state !== 2'd0) $display("FAIL rnd_timeout got %0d want 0", state);
      else n_pass++;
    end
    drive(0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    test_reset();
`ifdef VREC_PRETRIG_EN
    test_pretrig();
`else
    test_basic();
`endif
    test_early_stop();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
